dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the core's load/store path and a debug/loader port. The debug/loader port is used by the bench for memory preload and inspection through `addr_i`/`data_o`. The block sits between `riscv_singlecycle` and `DMEM` and sequences every access: one outstanding transaction, round-robin fairness, fixed memory latency. It stalls the core while the core's access is pending.

## Interface
- `XLEN`, default 32: data/address width.
- `MEM_LAT`, default 1: cycles from memory enable to read data valid. Legal range 1..7.
- `clk_i` input, 1: system clock.
- `rstn_i` input, 1: reset, asynchronous and active-low.
- `core_req_i` input, 1: core access request.
- `core_we_i` input, 1: 1 = store, 0 = load.
- `core_addr_i` input, XLEN: byte address.
- `core_wdata_i` input, XLEN: store data.
- `core_be_i` input, 4: byte enables.
- `core_gnt_o` output, 1: core request accepted this cycle.
- `core_rvalid_o` output, 1: core transaction complete, one-cycle pulse.
- `core_rdata_o` output, XLEN: last core load data.
- `core_stall_o` output, 1: freeze core PC/RF.
- `dbg_req_i`, `dbg_we_i`, `dbg_addr_i`, `dbg_wdata_i`, `dbg_be_i`: same meaning and widths as the core equivalents, for the debug/loader port.
- `dbg_gnt_o`, `dbg_rvalid_o`, `dbg_rdata_o`: same meaning and widths as the core equivalents, for the debug/loader port.
- `mem_en_o` output, 1: memory access strobe.
- `mem_we_o` output, 1: memory write enable.
- `mem_addr_o` output, XLEN: memory address.
- `mem_wdata_o` output, XLEN: memory write data.
- `mem_be_o` output, 4: memory byte enables.
- `mem_rdata_i` input, XLEN: memory read data, valid `MEM_LAT` cycles after `mem_en_o`.

## Operation
- States: `ARB_IDLE`, `ARB_WAIT`, `ARB_RESP`. Reset state is `ARB_IDLE`.
- `ARB_IDLE`:
  - If any request is present, pick a winner, assert its `gnt` and `mem_en_o`, and drive `mem_*` from the winner's fields.
  - Load the latency counter with `MEM_LAT-1`. Go to `ARB_WAIT`, or directly to `ARB_RESP` if `MEM_LAT`==1.
- `ARB_WAIT`: decrement the counter. At 0, go to `ARB_RESP`.
- `ARB_RESP`:
  - Pulse the owner's `rvalid`. For a load, capture `mem_rdata_i` into that port's `rdata` register.
  - A store leaves `rdata` unchanged and still pulses `rvalid` as its write acknowledge.
  - Go to `ARB_IDLE`.
- Round-robin:
  - A 1-bit last-owner pointer, reset to DBG so the core wins the first tie.
  - On simultaneous requests, the port that is not the last owner wins.
  - A lone request always wins. The pointer updates only on grant.
- Requester rule: `req` and all request fields hold stable until `gnt`. The arbiter does not check this.
- `core_stall_o` = `core_req_i` & ~`core_rvalid_o`. It is combinational.
- `mem_*` outputs are 0 in every cycle except the grant cycle.
- No alignment or byte-enable checking; fields pass through unchanged.

## Timing
- Reset values: all `gnt`, `rvalid`, `mem_en_o`, `mem_we_o` = 0. `mem_addr_o`, `mem_wdata_o`, `mem_be_o` = 0. Both `rdata` registers = 0. Counter = 0. Pointer = DBG.
- `gnt` and `mem_*` are combinational from `ARB_IDLE` and the requests. `rvalid` and `rdata` are registered state outputs.
- Grant at cycle T. `mem_rdata_i` is sampled at T+`MEM_LAT`. `rvalid` is high during T+`MEM_LAT`, with `rdata` updated from the next edge.
- The earliest next grant is T+`MEM_LAT`+1, so throughput is one access per `MEM_LAT`+1 cycles.
- No grant in `ARB_WAIT` or `ARB_RESP`. Requests arriving there wait.
- Reset mid-transaction: the transaction is dropped and no `rvalid` is produced. All state returns to its reset value asynchronously.
- A request deasserted before `gnt` is simply not serviced.

## Structure
- `riscv_pkg` holds:
  - `XLEN`
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT, ARB_RESP} arb_state_e`
  - `typedef enum logic {REQ_CORE, REQ_DBG} arb_id_e`
- Sub-module `rr_arbiter2`: combinational 2-way round-robin picker. Inputs are the requests and the last-owner pointer; outputs are the one-hot grant and the winner id.
- The top holds the FSM, latency counter, owner register, pointer and rdata registers.

## Test plan
- After reset, a core load of address 0x10 with `MEM_LAT`=1 and memory returning 0xDEADBEEF: `core_gnt_o` at T, `core_rvalid_o` at T+1, `core_rdata_o`=0xDEADBEEF after T+1, `core_stall_o` high T..T, low at T+1.
- Both ports request continuously: grants alternate CORE, DBG, CORE, DBG, with each grant 2 cycles apart at `MEM_LAT`=1.
- With `MEM_LAT`=3, a debug store of 0x12345678 to 0x40 with be 4'hF: `mem_en_o`=1, `mem_we_o`=1, `mem_addr_o`=0x40 at T; `dbg_rvalid_o` at T+3; `dbg_rdata_o` unchanged.
- A core request asserted while the arbiter is in `ARB_WAIT` for debug is not granted until `ARB_IDLE`. `core_stall_o` stays high throughout.
- `rstn_i` asserted during `ARB_WAIT`: all outputs go to 0 immediately and no `rvalid` appears. After release, the first tie is won by the core.
- A core byte load with be 4'h1 at 0x3 passes through unchanged: `mem_be_o`=4'h1, `mem_addr_o`=0x3.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the data-memory arbiter slice: datapath width,
// arbiter FSM states and requester ids.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT, ARB_RESP} arb_state_e;
    typedef enum logic {REQ_CORE, REQ_DBG} arb_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin picker: on a tie the port that did not
// own the previous grant wins; a lone request always wins.
module rr_arbiter2
    import riscv_pkg::*;
(
    input  logic       i_req_core,
    input  logic       i_req_dbg,
    input  arb_id_e    i_last,
    output logic [1:0] o_gnt,
    output arb_id_e    o_id
);

    always_comb begin
        o_id = REQ_CORE;
        if (i_req_core && i_req_dbg) begin
            o_id = (i_last == REQ_CORE) ? REQ_DBG : REQ_CORE;
        end else if (i_req_dbg) begin
            o_id = REQ_DBG;
        end

        o_gnt = '0;
        if (i_req_core || i_req_dbg) begin
            o_gnt = (o_id == REQ_DBG) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core load/store path and
// the debug/loader port: one outstanding access, fixed memory latency.
module dmem_arbiter #(
    parameter int unsigned XLEN    = riscv_pkg::XLEN,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic            clk_i,
    input  logic            rstn_i,

    input  logic            core_req_i,
    input  logic            core_we_i,
    input  logic [XLEN-1:0] core_addr_i,
    input  logic [XLEN-1:0] core_wdata_i,
    input  logic [3:0]      core_be_i,
    output logic            core_gnt_o,
    output logic            core_rvalid_o,
    output logic [XLEN-1:0] core_rdata_o,
    output logic            core_stall_o,

    input  logic            dbg_req_i,
    input  logic            dbg_we_i,
    input  logic [XLEN-1:0] dbg_addr_i,
    input  logic [XLEN-1:0] dbg_wdata_i,
    input  logic [3:0]      dbg_be_i,
    output logic            dbg_gnt_o,
    output logic            dbg_rvalid_o,
    output logic [XLEN-1:0] dbg_rdata_o,

    output logic            mem_en_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [3:0]      mem_be_o,
    input  logic [XLEN-1:0] mem_rdata_i
);

    import riscv_pkg::*;

    arb_state_e      r_state;
    logic [2:0]      r_cnt;
    arb_id_e         r_owner;
    logic            r_owner_we;
    arb_id_e         r_ptr;
    logic            r_core_rvalid;
    logic            r_dbg_rvalid;
    logic [XLEN-1:0] r_core_rdata;
    logic [XLEN-1:0] r_dbg_rdata;

    logic [1:0]      w_gnt;
    arb_id_e         w_win_id;
    logic            w_grant;

    rr_arbiter2 u_rr (
        .i_req_core (core_req_i),
        .i_req_dbg  (dbg_req_i),
        .i_last     (r_ptr),
        .o_gnt      (w_gnt),
        .o_id       (w_win_id)
    );

    assign w_grant = (r_state == ARB_IDLE) && (core_req_i || dbg_req_i);

    assign core_gnt_o    = w_grant && w_gnt[0];
    assign dbg_gnt_o     = w_grant && w_gnt[1];
    assign core_rvalid_o = r_core_rvalid;
    assign dbg_rvalid_o  = r_dbg_rvalid;
    assign core_rdata_o  = r_core_rdata;
    assign dbg_rdata_o   = r_dbg_rdata;
    assign core_stall_o  = core_req_i && !r_core_rvalid;

    // Memory strobe and fields exist only in the grant cycle; zero otherwise.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (w_grant) begin
            mem_en_o = 1'b1;
            if (w_win_id == REQ_DBG) begin
                mem_we_o    = dbg_we_i;
                mem_addr_o  = dbg_addr_i;
                mem_wdata_o = dbg_wdata_i;
                mem_be_o    = dbg_be_i;
            end else begin
                mem_we_o    = core_we_i;
                mem_addr_o  = core_addr_i;
                mem_wdata_o = core_wdata_i;
                mem_be_o    = core_be_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state       <= ARB_IDLE;
            r_cnt         <= '0;
            r_owner       <= REQ_CORE;
            r_owner_we    <= 1'b0;
            r_ptr         <= REQ_DBG;
            r_core_rvalid <= 1'b0;
            r_dbg_rvalid  <= 1'b0;
            r_core_rdata  <= '0;
            r_dbg_rdata   <= '0;
        end else begin
            r_core_rvalid <= 1'b0;
            r_dbg_rvalid  <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant) begin
                        r_owner    <= w_win_id;
                        r_ptr      <= w_win_id;
                        r_owner_we <= mem_we_o;
                        r_cnt      <= 3'(MEM_LAT - 1);
                        if (MEM_LAT == 1) begin
                            r_state       <= ARB_RESP;
                            r_core_rvalid <= (w_win_id == REQ_CORE);
                            r_dbg_rvalid  <= (w_win_id == REQ_DBG);
                        end else begin
                            r_state <= ARB_WAIT;
                        end
                    end
                end
                ARB_WAIT: begin
                    // rvalid is raised on the edge that enters ARB_RESP.
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_state       <= ARB_RESP;
                        r_core_rvalid <= (r_owner == REQ_CORE);
                        r_dbg_rvalid  <= (r_owner == REQ_DBG);
                    end
                end
                ARB_RESP: begin
                    if (!r_owner_we) begin
                        if (r_owner == REQ_CORE) begin
                            r_core_rdata <= mem_rdata_i;
                        end else begin
                            r_dbg_rdata <= mem_rdata_i;
                        end
                    end
                    r_state <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule
